// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII transmit scheduler.
// The CRC helper is used by crc32_d8 when GMII_TX_SCHED_FCS_EN is defined.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_DROP = 3'd4,
    ST_IFG  = 3'd5,
    ST_FCS  = 3'd6
  } tx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;

  // Reflected CRC-32 update of one byte, bit 0 of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] poly_r;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) begin
      poly_r[i] = CRC32_POLY[31-i];
    end
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = {1'b0, c[31:1]} ^ poly_r;
      end else begin
        c = {1'b0, c[31:1]};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_tx_sched_crc32_d8.sv
// Byte-parallel reflected CRC-32 accumulator with synchronous clear and enable.
// Instantiated by gmii_tx_sched only when GMII_TX_SCHED_FCS_EN is defined.
module crc32_d8
  import gmii_tx_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;

  // CRC state register: clear wins over update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      crc_q <= CRC32_INIT;
    end else if (clr_i) begin
      crc_q <= CRC32_INIT;
    end else if (en_i) begin
      crc_q <= crc32_byte(crc_q, data_i);
    end else begin
      crc_q <= crc_q;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/gmii_tx_sched.sv
// Round-robin frame scheduler for two byte-stream requesters feeding a GMII transmitter.
// Define GMII_TX_SCHED_FCS_EN to append a generated CRC-32 FCS after each good frame.
module gmii_tx_sched
  import gmii_tx_pkg::*;
#(
  parameter int IFG_CYCLES   = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic       gmii_tx_clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic [1:0] grant,
  output logic       busy,
  output logic       underrun
);

  tx_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] grant_q, grant_d;
  logic       rr_last_q, rr_last_d;
  logic       tx_en_q, tx_en_d;
  logic [7:0] txd_q, txd_d;
  logic       underrun_q, underrun_d;
  logic       busy_q;

  logic       g_valid, g_last, pick1, rx_phase;
  logic [7:0] g_data;

  assign g_valid  = grant_q[1] ? req1_valid : req0_valid;
  assign g_last   = grant_q[1] ? req1_last  : req0_last;
  assign g_data   = grant_q[1] ? req1_data  : req0_data;
  // On a tie the requester not served last wins.
  assign pick1    = req1_valid & (~req0_valid | ~rr_last_q);
  assign rx_phase = (state_q == ST_SFD) | (state_q == ST_DATA) | (state_q == ST_DROP);

  assign req0_ready = rx_phase & grant_q[0];
  assign req1_ready = rx_phase & grant_q[1];

`ifdef GMII_TX_SCHED_FCS_EN
  logic [31:0] crc;
  logic [31:0] fcs;

  crc32_d8 u_crc (
    .clk_i  (gmii_tx_clk),
    .rst_i  (rst),
    .clr_i  (state_q == ST_IDLE),
    .en_i   (g_valid & ((state_q == ST_SFD) | (state_q == ST_DATA))),
    .data_i (g_data),
    .crc_o  (crc)
  );

  assign fcs = ~crc;
`endif

  // Next-state and next-output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    rr_last_d  = rr_last_q;
    tx_en_d    = 1'b0;
    txd_d      = 8'h00;
    underrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0_valid | req1_valid) begin
          grant_d   = pick1 ? 2'b10 : 2'b01;
          rr_last_d = pick1;
          state_d   = ST_PRE;
          cnt_d     = 8'd1;
          tx_en_d   = 1'b1;
          txd_d     = PREAMBLE_BYTE;
        end else begin
          cnt_d = 8'd0;
        end
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q == 8'(PREAMBLE_LEN)) begin
          state_d = ST_SFD;
          txd_d   = SFD_BYTE;
        end else begin
          cnt_d = cnt_q + 8'd1;
          txd_d = PREAMBLE_BYTE;
        end
      end
      ST_SFD, ST_DATA: begin
        if (g_valid) begin
          tx_en_d = 1'b1;
          txd_d   = g_data;
          if (g_last) begin
            cnt_d = 8'd0;
`ifdef GMII_TX_SCHED_FCS_EN
            state_d = ST_FCS;
`else
            state_d = ST_IFG;
            grant_d = 2'b00;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          underrun_d = 1'b1;
          state_d    = ST_DROP;
        end
      end
      ST_DROP: begin
        // The low cycles after the final discarded byte form the gap.
        if (g_valid & g_last) begin
          grant_d = 2'b00;
          cnt_d   = 8'd1;
          state_d = (IFG_CYCLES == 1) ? ST_IDLE : ST_IFG;
        end else begin
          state_d = ST_DROP;
        end
      end
`ifdef GMII_TX_SCHED_FCS_EN
      ST_FCS: begin
        tx_en_d = 1'b1;
        txd_d   = fcs[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == 8'd3) begin
          state_d = ST_IFG;
          grant_d = 2'b00;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      ST_IFG: begin
        if (cnt_q >= 8'(IFG_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      grant_q    <= 2'b00;
      rr_last_q  <= 1'b1;
      tx_en_q    <= 1'b0;
      txd_q      <= 8'h00;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      rr_last_q  <= rr_last_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      underrun_q <= underrun_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign gmii_tx_en = tx_en_q;
  assign gmii_txd   = txd_q;
  assign grant      = grant_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Randomized bench for gmii_tx_sched: requester drivers plus a frame-level timeline model.
module tb_gmii_tx_sched;

  localparam int IFG = 12;
  localparam int PL  = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, gmii_txd;
  logic       gmii_tx_en, busy, underrun;
  logic [1:0] grant;

  always #4 clk = ~clk;

  gmii_tx_sched #(.IFG_CYCLES(IFG), .PREAMBLE_LEN(PL)) dut (
    .gmii_tx_clk (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .grant       (grant),
    .busy        (busy),
    .underrun    (underrun)
  );

  typedef struct packed {
    logic       en;
    logic [7:0] txd;
    logic [1:0] grant;
    logic [1:0] rdy;
    logic       und;
    logic       busy;
  } exp_t;

  exp_t       tl [$];
  logic [7:0] bq [2][$];
  int         fl [2][$];
  int         fg [2][$];
  int         pos [2];
  bit         gap_done [2];
  logic       vld [2];
  logic       lst [2];
  logic [7:0] dat [2];
  int         rr;
  int         total = 0;
  int         bad = 0;

  assign req0_valid = vld[0];
  assign req0_last  = lst[0];
  assign req0_data  = dat[0];
  assign req1_valid = vld[1];
  assign req1_last  = lst[1];
  assign req1_data  = dat[1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic en, input logic [7:0] d, input logic [1:0] g,
                              input logic [1:0] rdy, input logic und, input logic bsy);
    exp_t e;
    e.en = en; e.txd = d; e.grant = g; e.rdy = rdy; e.und = und; e.busy = bsy;
    return e;
  endfunction

  function automatic logic [31:0] crc_ref(input int r, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, bq[r][i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  // Expected wire/handshake timeline of one granted frame, from the cycle after the grant.
  task automatic gen(input int r);
    logic [1:0]  g;
    logic [31:0] fcs;
    int n, m, fwd;
    g   = (r == 1) ? 2'b10 : 2'b01;
    n   = fl[r][0];
    m   = fg[r][0];
    fcs = crc_ref(r, n);
    for (int i = 0; i < PL; i++) tl.push_back(mk(1'b1, 8'h55, g, 2'b00, 1'b0, 1'b1));
    tl.push_back(mk(1'b1, 8'hD5, g, g, 1'b0, 1'b1));
    fwd = (m == 0) ? n - 1 : m;
    for (int i = 1; i <= fwd; i++) tl.push_back(mk(1'b1, bq[r][i-1], g, g, 1'b0, 1'b1));
    if (m == 0) begin
`ifdef GMII_TX_SCHED_FCS_EN
      tl.push_back(mk(1'b1, bq[r][n-1], g, 2'b00, 1'b0, 1'b1));
      for (int i = 0; i < 3; i++) tl.push_back(mk(1'b1, fcs[8*i +: 8], g, 2'b00, 1'b0, 1'b1));
      tl.push_back(mk(1'b1, fcs[31:24], 2'b00, 2'b00, 1'b0, 1'b1));
`else
      tl.push_back(mk(1'b1, bq[r][n-1], 2'b00, 2'b00, 1'b0, 1'b1));
`endif
    end else begin
      for (int j = 0; j < n - m; j++) tl.push_back(mk(1'b0, 8'h00, g, g, (j == 0), 1'b1));
    end
    for (int i = 0; i < IFG - 1; i++) tl.push_back(mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b1));
  endtask

  task automatic drive();
    for (int r = 0; r < 2; r++) begin
      if (fl[r].size() == 0) begin
        vld[r] = 1'b0; dat[r] = 8'h00; lst[r] = 1'b0;
      end else begin
        dat[r] = bq[r][0];
        lst[r] = (pos[r] == fl[r][0] - 1);
        if (fg[r][0] > 0 && pos[r] == fg[r][0] && !gap_done[r]) begin
          vld[r] = 1'b0;
          gap_done[r] = 1'b1;
        end else begin
          vld[r] = 1'b1;
        end
      end
    end
  endtask

  task automatic accept(input int r);
    void'(bq[r].pop_front());
    pos[r]++;
    if (pos[r] == fl[r][0]) begin
      void'(fl[r].pop_front());
      void'(fg[r].pop_front());
      pos[r] = 0;
      gap_done[r] = 1'b0;
    end
  endtask

  // One clock cycle: drive, predict, check on the falling edge, then handshake.
  task automatic step(input bit rst_now);
    exp_t e;
    logic a0, a1;
    int   w;
    rst = rst_now;
    if (rst_now) begin
      for (int r = 0; r < 2; r++) begin
        bq[r].delete(); fl[r].delete(); fg[r].delete();
        pos[r] = 0; gap_done[r] = 1'b0;
      end
    end
    drive();
    if (tl.size() > 0) begin
      e = tl.pop_front();
    end else begin
      e = mk(1'b0, 8'h00, 2'b00, 2'b00, 1'b0, 1'b0);
      if (!rst_now && (vld[0] || vld[1])) begin
        w  = (vld[1] && (!vld[0] || rr == 0)) ? 1 : 0;
        rr = w;
        gen(w);
      end
    end
    @(negedge clk);
    chk("tx_en", gmii_tx_en, e.en);
    if (e.en) chk("txd", gmii_txd, e.txd);
    chk("grant", grant, e.grant);
    chk("ready", {req1_ready, req0_ready}, e.rdy);
    chk("underrun", underrun, e.und);
    chk("busy", busy, e.busy);
    a0 = req0_valid & req0_ready;
    a1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
    if (rst_now) begin
      tl.delete();
      rr = 1;
    end else begin
      if (a0) accept(0);
      if (a1) accept(1);
    end
  endtask

  // mode 0: incrementing from b0, 1: random, 2: constant b0
  task automatic add(input int r, input int n, input int m, input logic [7:0] b0, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 1) bq[r].push_back(8'($urandom));
      else if (mode == 2) bq[r].push_back(b0);
      else bq[r].push_back(b0 + 8'(i));
    end
    fl[r].push_back(n);
    fg[r].push_back(m);
  endtask

  task automatic run();
    int c;
    c = 0;
    while ((tl.size() > 0 || fl[0].size() > 0 || fl[1].size() > 0) && c < 3000) begin
      step(1'b0);
      c++;
    end
    chk("drain", tl.size() + fl[0].size() + fl[1].size(), 0);
    step(1'b0);
  endtask

  task automatic chk_reset_state();
    chk("rst_tx_en", gmii_tx_en, 0);
    chk("rst_txd", gmii_txd, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, n, m;
    rst = 1'b1;
    rr  = 1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; lst[i] = 1'b0; dat[i] = 8'h00; pos[i] = 0; gap_done[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state();
    step(1'b0);
    step(1'b0);

    // tie out of reset: req0, req1, req0
    add(0, 2, 0, 8'h10, 0);
    add(0, 2, 0, 8'h12, 0);
    add(1, 2, 0, 8'h20, 0);
    run();

    add(0, 4, 0, 8'h01, 0);
    run();

    // underrun after byte 3 of 10
    add(1, 10, 3, 8'h30, 0);
    run();

    add(0, 1, 0, 8'hAB, 0);
    run();

    // reset in the middle of a data phase
    add(0, 8, 0, 8'h40, 0);
    repeat (PL + 4) step(1'b0);
    step(1'b1);
    chk_reset_state();
    add(1, 3, 0, 8'h50, 0);
    run();

    add(0, 60, 0, 8'h00, 2);
    run();

    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(1, 0));
      n = int'($urandom_range(20, 1));
      m = (n > 1 && ($urandom % 4) == 0) ? int'($urandom_range(n - 1, 1)) : 0;
      add(r, n, m, 8'h00, 1);
      if (k % 5 == 4) begin
        run();
        repeat ($urandom % 3) step(1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
